// File: rtl/term_writer_if.sv
// Byte-stream input and terminal write-request bus for term_writer.
// master: the writer (consumes bytes, issues terminal writes).
// slave: the environment (byte producer plus terminal).
interface term_writer_if #(
    parameter int XBITS = 7,
    parameter int YBITS = 5
) ();
    logic [7:0]       in_data;
    logic             in_valid;
    logic             in_ready;
    logic [XBITS-1:0] xwrite;
    logic [YBITS-1:0] ywrite;
    logic [7:0]       charin;
    logic             writereq;
    logic             writeack;

    modport master (
        input  in_data, in_valid, writeack,
        output in_ready, xwrite, ywrite, charin, writereq
    );

    modport slave (
        output in_data, in_valid, writeack,
        input  in_ready, xwrite, ywrite, charin, writereq
    );
endinterface

// File: rtl/term_writer.sv
// Cursor-tracking character writer. Turns a byte stream into single-cell
// terminal writes, handling CR, LF, BS and FF (clear screen), and keeps the
// cursor in range for a non-power-of-two column count.
module term_writer #(
    parameter int COLS   = 100,
    parameter int ROWS   = 32,
    parameter int XBITS  = 7,
    parameter int YBITS  = 5,
    parameter int UPCASE = 1
) (
    input  logic             clk,
    input  logic             rst,
    term_writer_if.master    bus,
    output logic [XBITS-1:0] curx,
    output logic [YBITS-1:0] cury,
    output logic             busy
);

    localparam logic [XBITS-1:0] XMAX  = XBITS'(COLS - 1);
    localparam logic [YBITS-1:0] YMAX  = YBITS'(ROWS - 1);
    localparam logic [XBITS-1:0] XONE  = XBITS'(1);
    localparam logic [YBITS-1:0] YONE  = YBITS'(1);
    localparam logic [7:0]       SPACE = 8'h20;

    localparam logic [7:0] CH_BS = 8'h08;
    localparam logic [7:0] CH_LF = 8'h0A;
    localparam logic [7:0] CH_FF = 8'h0C;
    localparam logic [7:0] CH_CR = 8'h0D;

    typedef enum logic [2:0] {
        S_DRAIN,
        S_IDLE,
        S_REQ,
        S_DONE,
        S_CLR
    } state_t;

    // What the write in flight was for, so DONE knows the follow-up action.
    typedef enum logic [1:0] {
        K_CHAR,
        K_BS,
        K_CLR
    } kind_t;

    state_t           state;
    kind_t            kind;
    logic [XBITS-1:0] clrx;
    logic [YBITS-1:0] clry;

    // Lower-case letters map onto the upper-case glyphs of a 64-glyph font.
    function automatic logic [7:0] fold(input logic [7:0] b);
        if (UPCASE != 0 && b >= 8'h61 && b <= 8'h7A) begin
            return b - 8'h20;
        end
        return b;
    endfunction

    // Row advance wraps to the top; there is no scrolling.
    function automatic logic [YBITS-1:0] next_row(input logic [YBITS-1:0] y);
        return (y == YMAX) ? '0 : y + YONE;
    endfunction

    function automatic logic is_printable(input logic [7:0] b);
        return (b >= 8'h20 && b <= 8'h7E);
    endfunction

    assign busy = (state != S_IDLE);

    // Single sequencer: byte decode, write handshake, clear walk and cursor.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= S_DRAIN;
            kind         <= K_CHAR;
            bus.writereq <= 1'b0;
            bus.in_ready <= 1'b0;
            bus.xwrite   <= '0;
            bus.ywrite   <= '0;
            bus.charin   <= SPACE;
            curx         <= '0;
            cury         <= '0;
            clrx         <= '0;
            clry         <= '0;
        end else begin
            case (state)
                // A reset may have cut a write short; let the terminal's ack
                // fall before anything new is requested.
                S_DRAIN: begin
                    if (!bus.writeack) begin
                        state        <= S_IDLE;
                        bus.in_ready <= 1'b1;
                    end
                end

                S_IDLE: begin
                    if (!bus.in_ready) begin
                        // Recovery cycle after a byte that needed no write.
                        bus.in_ready <= 1'b1;
                    end else if (bus.in_valid) begin
                        bus.in_ready <= 1'b0;
                        if (is_printable(bus.in_data)) begin
                            bus.xwrite   <= curx;
                            bus.ywrite   <= cury;
                            bus.charin   <= fold(bus.in_data);
                            bus.writereq <= 1'b1;
                            kind         <= K_CHAR;
                            state        <= S_REQ;
                        end else begin
                            case (bus.in_data)
                                CH_CR: begin
                                    curx <= '0;
                                end
                                CH_LF: begin
                                    curx <= '0;
                                    cury <= next_row(cury);
                                end
                                CH_BS: begin
                                    if (curx != '0) begin
                                        curx         <= curx - XONE;
                                        bus.xwrite   <= curx - XONE;
                                        bus.ywrite   <= cury;
                                        bus.charin   <= SPACE;
                                        bus.writereq <= 1'b1;
                                        kind         <= K_BS;
                                        state        <= S_REQ;
                                    end
                                end
                                CH_FF: begin
                                    clrx  <= '0;
                                    clry  <= '0;
                                    kind  <= K_CLR;
                                    state <= S_CLR;
                                end
                                default: begin
                                end
                            endcase
                        end
                    end
                end

                // Request held with stable coordinates until the terminal acks;
                // it is dropped on the ack edge so it never outlives the ack.
                S_REQ: begin
                    if (bus.writeack) begin
                        bus.writereq <= 1'b0;
                        state        <= S_DONE;
                    end
                end

                S_DONE: begin
                    if (!bus.writeack) begin
                        case (kind)
                            K_CHAR: begin
                                if (curx == XMAX) begin
                                    curx <= '0;
                                    cury <= next_row(cury);
                                end else begin
                                    curx <= curx + XONE;
                                end
                                bus.in_ready <= 1'b1;
                                state        <= S_IDLE;
                            end
                            K_BS: begin
                                bus.in_ready <= 1'b1;
                                state        <= S_IDLE;
                            end
                            default: begin
                                if (clrx == XMAX) begin
                                    clrx <= '0;
                                    if (clry == YMAX) begin
                                        clry         <= '0;
                                        curx         <= '0;
                                        cury         <= '0;
                                        bus.in_ready <= 1'b1;
                                        state        <= S_IDLE;
                                    end else begin
                                        clry  <= clry + YONE;
                                        state <= S_CLR;
                                    end
                                end else begin
                                    clrx  <= clrx + XONE;
                                    state <= S_CLR;
                                end
                            end
                        endcase
                    end
                end

                // Present the next blank cell of the clear walk.
                S_CLR: begin
                    bus.xwrite   <= clrx;
                    bus.ywrite   <= clry;
                    bus.charin   <= SPACE;
                    bus.writereq <= 1'b1;
                    state        <= S_REQ;
                end

                default: begin
                    bus.writereq <= 1'b0;
                    bus.in_ready <= 1'b0;
                    state        <= S_DRAIN;
                end
            endcase
        end
    end

endmodule

// File: doc/term_writer.md
Name: term_writer

Overview:
- Cursor-tracking character writer that drives the terminal's write-request interface (xwrite, ywrite, charin, writereq/writeack) from a byte stream.
- Accepts bytes over a valid/ready handshake and interprets printable characters and a small set of control codes (CR, LF, BS, FF).
- Sequences one terminal write at a time, so upstream logic (UART receiver, CPU port) never deals with screen coordinates.

Parameters:
- COLS, 100, visible columns; cursor x range 0..COLS-1
- ROWS, 32, visible rows; cursor y range 0..ROWS-1
- XBITS, 7, width of xwrite and curx
- YBITS, 5, width of ywrite and cury
- UPCASE, 1, when 1, bytes 0x61..0x7A are written as byte-0x20 (64-glyph font)

Ports:
- clk  in  1  system clock, same domain as terminal
- rst  in  1  synchronous active-high reset
- in_data  in  8  byte to process
- in_valid  in  1  in_data valid
- in_ready  out  1  block can accept a byte this cycle
- xwrite  out  XBITS  terminal write column
- ywrite  out  YBITS  terminal write row
- charin  out  8  terminal write character
- writereq  out  1  terminal write request
- writeack  in  1  terminal acknowledge/busy
- curx  out  XBITS  current cursor column
- cury  out  YBITS  current cursor row
- busy  out  1  high whenever the block is not in IDLE

Behaviour:
- Reset (sampled at posedge clk while rst=1):
  - writereq=0, in_ready=0, busy=1, curx=0, cury=0, xwrite=0, ywrite=0, charin=0x20.
  - State becomes DRAIN.
- Byte acceptance: a byte is taken on a posedge with in_valid&&in_ready. in_ready is registered; it is 1 only in IDLE and drops the cycle after acceptance.
- Byte classes:
  - Printable 0x20..0x7E: load xwrite=curx, ywrite=cury, charin=byte (folded if UPCASE), go to REQ.
  - 0x0D CR: curx=0; go to IDLE, no write.
  - 0x0A LF: curx=0, cury=cury+1 (wrap to 0 after ROWS-1); no write.
  - 0x08 BS: if curx>0, curx=curx-1, then write 0x20 at the new position through REQ. If curx=0, no-op.
  - 0x0C FF: clear screen via CLR, then home the cursor.
  - All other bytes: discarded, no cursor change.
  - Non-writing bytes take one processing cycle; in_ready is low for exactly one cycle after acceptance.
- States:
  - DRAIN: wait for writeack=0, then go to IDLE. Covers a reset that lands mid-write.
  - IDLE: in_ready=1, busy=0.
  - REQ: writereq=1, with xwrite/ywrite/charin held stable. On writeack=1, go to DONE.
  - DONE: writereq=0 on the same edge the state is entered. Wait for writeack=0, then run the post-write action and go to IDLE (or back to CLR).
  - CLR: set xwrite/ywrite to the clear counter, charin=0x20, go to REQ.
- writereq deassertion is mandatory before writeack falls. The terminal re-captures any request held while writeack=0.
- Post-write actions:
  - Printable write: curx+1. If curx was COLS-1, set curx=0 and advance cury, wrapping after ROWS-1 to row 0 (no scrolling).
  - BS write: cursor unchanged.
  - FF clear: counter walks row-major, y 0..ROWS-1 outer, x 0..COLS-1 inner; COLS*ROWS writes total. After the last cell, curx=cury=0 and go to IDLE.
- In-range guarantee: xwrite and ywrite never exceed COLS-1 / ROWS-1.
- Width rules: counters compare against COLS-1 and ROWS-1 explicitly, never rely on XBITS/YBITS overflow. 100 columns is not a power of two.
- rst asserted in any state (including mid-clear):
  - Aborts at the next edge and applies the reset values.
  - The pending write may or may not complete in the terminal; no retry is made.
  - DRAIN prevents overlap with the terminal's in-flight ack.
- in_valid held while busy: ignored until in_ready=1; no byte is lost or duplicated.

Test Plan:
- Printable write: bench terminal model acks 3 cycles after req and releases 5 cycles later. After reset, send 'A'(0x41) -> one writereq pulse with xwrite=0, ywrite=0, charin=0x41, held until ack=1; then curx=1, in_ready back to 1.
- Line wrap: set cursor to (99,31) via 31 LFs plus 99 chars, send 'Z' -> write at (99,31), then curx=0, cury=0.
- Control codes at boundaries:
  - 'ab' with UPCASE=1 -> charin 0x41, 0x42.
  - CR -> curx=0 with no writereq.
  - BS at curx=2 -> write 0x20 at (1,y), curx=1.
  - BS at curx=0 -> no write.
- Clear screen: FF -> exactly 3200 writes of 0x20 covering (0,0)..(99,31) row-major with no duplicates; then cursor (0,0), busy=0.
- Reset mid-clear: assert rst for 1 cycle during write 500 while writeack=1. Check writereq=0 next cycle, in_ready stays 0 until writeack falls, then the next byte writes at (0,0).
- Handshake protocol check: a protocol monitor over all scenarios confirms:
  - writereq never asserted while writeack=1 from a previous write.
  - Outputs stable throughout REQ.
  - Bytes 0x00 and 0x7F are ignored.
